rv32v_mem_lane_sequencer: RTL and testbench
===========================================

RV32V_MEM_LANE_SEQUENCER -- requirements
Module: rv32v_mem_lane_sequencer

Interface
REQ-001 Parameters: none; SEW encoding fixed as eew 2'b00=8b, 2'b01=16b, 2'b10=32b, 2'b11 reserved.
REQ-002 CLK  in  1  sole clock, all state on rising edge.
REQ-003 nRST  in  1  asynchronous active-low reset.
REQ-004 load, store  in  1 each  memory-op request from execute; load wins if both high.
REQ-005 wen0, wen1  in  1 each  lane-active flags.
REQ-006 aluresult0, aluresult1  in  32 each  lane byte addresses.
REQ-007 storedata0, storedata1  in  32 each  lane store data, LSB-aligned.
REQ-008 eew  in  2  element width.
REQ-009 vd  in  5  destination vector register.
REQ-010 mem_ready  out  1  sequencer idle, request accepted this cycle if present.
REQ-011 dmem_ren, dmem_wen  out  1 each  data-memory read/write strobes.
REQ-012 dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-013 dmem_wdata  out  32, dmem_byte_en  out  4  lane-positioned store data and byte strobes.
REQ-014 dmem_rdata  in  32, dmem_busy  in  1  read data; access completes in cycle busy is low.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 wb_wen0, wb_wen1  out  1 each; wb_data0, wb_data1  out  32 each; wb_vd  out  5  load writeback, valid only with done.
REQ-017 misaligned  out  1  high with done if any active lane was misaligned.

Function
REQ-018 FSM states IDLE, LANE0, LANE1, DONE; mem_ready = (state==IDLE).
REQ-019 Accept when IDLE & (load|store) & (wen0|wen1): capture op, both lanes' addr/data/wen, eew, vd; next state LANE0 if wen0 else LANE1.
REQ-020 Request with wen0=wen1=0 is not accepted; no access, no done.
REQ-021 Execute holds request while mem_ready low; inputs ignored outside IDLE.
REQ-022 LANEn: drive dmem_ren (load) or dmem_wen (store) for lane n; hold all dmem outputs stable until dmem_busy low.
REQ-023 LANE0 completion -> LANE1 if captured wen1 else DONE; LANE1 completion -> DONE.
REQ-024 DONE lasts exactly one cycle: done=1, wb_wen0/1 = load & captured wen0/1, then IDLE.
REQ-025 Byte enables: 8b -> 4'b0001<<addr[1:0]; 16b -> 4'b0011<<{addr[1],1'b0}; 32b -> 4'b1111.
REQ-026 Store data shifted left by 8*addr[1:0] (8b) or 16*addr[1] (16b); 32b unshifted.
REQ-027 Load data extracted from same lane position, zero-extended to 32b, registered at completion.
REQ-028 Misaligned lane (16b addr[0]=1; 32b addr[1:0]!=0; eew=2'b11): no strobe issued, lane completes in one cycle, wb_wen for that lane 0, misaligned=1 in DONE.
REQ-029 Zero-wait memory latency: accept T, lane accesses T+1 (and T+2), done next cycle, mem_ready high cycle after done.
REQ-030 dmem strobes, done, wb_wen0/1 low in IDLE; dmem_ren and dmem_wen never both high.

Reset
REQ-031 nRST low forces IDLE asynchronously; all outputs 0 except mem_ready=1 after release.
REQ-032 Reset mid-access abandons the access immediately; no done pulse follows.

Verification
REQ-033 Load, wen0=wen1=1, eew=32b, addrs 0x100/0x104, busy=0, rdata 0xAAAA5555 then 0x12345678 -> reads at 0x100,0x104 in T+1,T+2; done T+3 with wb_data0=0xAAAA5555, wb_data1=0x12345678, wb_wen0=wb_wen1=1.
REQ-034 Store, wen0 only, eew=8b, addr 0x203, data 0xEF -> one write, addr 0x200, byte_en 4'b1000, wdata 0xEF000000; done with wb_wen0=wb_wen1=0.
REQ-035 Load, wen1 only, eew=16b, addr 0x302, busy high 3 cycles, rdata 0xBEEF0000 -> address held 4 cycles; wb_data1=0x0000BEEF.
REQ-036 Load eew=32b, lane0 addr 0x101, lane1 0x108 -> no access lane0, read 0x108 lane1; done with misaligned=1, wb_wen0=0, wb_wen1=1.
REQ-037 nRST asserted during LANE1 with busy high -> strobes drop same cycle, mem_ready=1 after release, no done.
REQ-038 load=store=1, wen0=1 -> read issued only; request with wen0=wen1=0 -> mem_ready stays 1, no strobes.

Source files
------------

// File: rtl/rv32v_mem_lane_sequencer.sv
// rtl/rv32v_mem_lane_sequencer.sv - two-lane vector load/store sequencer onto a single-port data memory
// Each active lane becomes one word access; misaligned lanes are skipped and flagged at completion.
module rv32v_mem_lane_sequencer (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        load,
  input  logic        store,
  input  logic        wen0,
  input  logic        wen1,
  input  logic [31:0] aluresult0,
  input  logic [31:0] aluresult1,
  input  logic [31:0] storedata0,
  input  logic [31:0] storedata1,
  input  logic [1:0]  eew,
  input  logic [4:0]  vd,
  output logic        mem_ready,
  output logic        dmem_ren,
  output logic        dmem_wen,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_en,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_busy,
  output logic        done,
  output logic        wb_wen0,
  output logic        wb_wen1,
  output logic [31:0] wb_data0,
  output logic [31:0] wb_data1,
  output logic [4:0]  wb_vd,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, LANE0, LANE1, DONE} state_t;

  state_t      state;
  logic        op_load;
  logic [1:0]  lane_wen;
  logic [1:0]  lane_mis;
  logic [31:0] addr0_r, addr1_r;
  logic [31:0] data0_r, data1_r;
  logic [1:0]  eew_r;
  logic [4:0]  vd_r;
  logic [31:0] wb_data0_r, wb_data1_r;

  function automatic logic lane_ok(input logic [1:0] e, input logic [1:0] a);
    case (e)
      2'b00:   lane_ok = 1'b1;
      2'b01:   lane_ok = ~a[0];
      2'b10:   lane_ok = (a == 2'b00);
      default: lane_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] e, input logic [1:0] a);
    case (e)
      2'b00:   lane_be = 4'b0001 << a;
      2'b01:   lane_be = 4'b0011 << {a[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [4:0] lane_shift(input logic [1:0] e, input logic [1:0] a);
    case (e)
      2'b00:   lane_shift = {a, 3'b000};
      2'b01:   lane_shift = {a[1], 4'b0000};
      default: lane_shift = 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] e);
    case (e)
      2'b00:   lane_mask = 32'h0000_00FF;
      2'b01:   lane_mask = 32'h0000_FFFF;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  logic        active, cur_ok, strobe, lane_done;
  logic [31:0] cur_addr, cur_data, cur_mask, rd_lane;
  logic [4:0]  cur_shift;

  // Memory-side signals decode straight from registered state so a reset drops them at once.
  always_comb begin
    active    = (state == LANE0) || (state == LANE1);
    cur_addr  = (state == LANE1) ? addr1_r : addr0_r;
    cur_data  = (state == LANE1) ? data1_r : data0_r;
    cur_ok    = lane_ok(eew_r, cur_addr[1:0]);
    cur_shift = lane_shift(eew_r, cur_addr[1:0]);
    cur_mask  = lane_mask(eew_r);
    strobe    = active && cur_ok;
    lane_done = active && (!cur_ok || !dmem_busy);
    rd_lane   = (dmem_rdata >> cur_shift) & cur_mask;
  end

  assign mem_ready    = (state == IDLE);
  assign dmem_ren     = strobe && op_load;
  assign dmem_wen     = strobe && !op_load;
  assign dmem_addr    = active ? {cur_addr[31:2], 2'b00} : 32'h0;
  assign dmem_byte_en = strobe ? lane_be(eew_r, cur_addr[1:0]) : 4'b0000;
  assign dmem_wdata   = dmem_wen ? ((cur_data & cur_mask) << cur_shift) : 32'h0;

  assign done       = (state == DONE);
  assign wb_wen0    = done && op_load && lane_wen[0] && !lane_mis[0];
  assign wb_wen1    = done && op_load && lane_wen[1] && !lane_mis[1];
  assign wb_data0   = wb_data0_r;
  assign wb_data1   = wb_data1_r;
  assign wb_vd      = vd_r;
  assign misaligned = done && (lane_mis != 2'b00);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      op_load    <= 1'b0;
      lane_wen   <= 2'b00;
      lane_mis   <= 2'b00;
      addr0_r    <= 32'h0;
      addr1_r    <= 32'h0;
      data0_r    <= 32'h0;
      data1_r    <= 32'h0;
      eew_r      <= 2'b00;
      vd_r       <= 5'd0;
      wb_data0_r <= 32'h0;
      wb_data1_r <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if ((load || store) && (wen0 || wen1)) begin
            op_load  <= load;
            lane_wen <= {wen1, wen0};
            lane_mis <= 2'b00;
            addr0_r  <= aluresult0;
            addr1_r  <= aluresult1;
            data0_r  <= storedata0;
            data1_r  <= storedata1;
            eew_r    <= eew;
            vd_r     <= vd;
            state    <= wen0 ? LANE0 : LANE1;
          end
        end
        LANE0: begin
          if (lane_done) begin
            if (!cur_ok)      lane_mis[0] <= 1'b1;
            else if (op_load) wb_data0_r  <= rd_lane;
            state <= lane_wen[1] ? LANE1 : DONE;
          end
        end
        LANE1: begin
          if (lane_done) begin
            if (!cur_ok)      lane_mis[1] <= 1'b1;
            else if (op_load) wb_data1_r  <= rd_lane;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32v_mem_lane_sequencer.sv
// tb/tb_rv32v_mem_lane_sequencer.sv - scoreboard bench for rv32v_mem_lane_sequencer
module tb_rv32v_mem_lane_sequencer;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        load = 1'b0, store = 1'b0, wen0 = 1'b0, wen1 = 1'b0;
  logic [31:0] aluresult0 = 32'h0, aluresult1 = 32'h0;
  logic [31:0] storedata0 = 32'h0, storedata1 = 32'h0;
  logic [1:0]  eew = 2'b00;
  logic [4:0]  vd = 5'd0;
  logic        mem_ready, dmem_ren, dmem_wen;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_byte_en;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_busy = 1'b0;
  logic        done, wb_wen0, wb_wen1, misaligned;
  logic [31:0] wb_data0, wb_data1;
  logic [4:0]  wb_vd;

  rv32v_mem_lane_sequencer dut (
    .CLK(CLK), .nRST(nRST), .load(load), .store(store), .wen0(wen0), .wen1(wen1),
    .aluresult0(aluresult0), .aluresult1(aluresult1),
    .storedata0(storedata0), .storedata1(storedata1), .eew(eew), .vd(vd),
    .mem_ready(mem_ready), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
    .dmem_rdata(dmem_rdata), .dmem_busy(dmem_busy), .done(done),
    .wb_wen0(wb_wen0), .wb_wen1(wb_wen1), .wb_data0(wb_data0), .wb_data1(wb_data1),
    .wb_vd(wb_vd), .misaligned(misaligned)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          hold;
  } acc_t;

  typedef struct {
    logic        w0, w1, mis;
    logic [31:0] d0, d1;
    logic [4:0]  vd;
    int          acc_cyc;
    int          lat;
  } res_t;

  acc_t        acc_q[$];
  res_t        res_q[$];
  logic [31:0] rd_vals[$];
  acc_t        ea;
  res_t        er;
  int total = 0, bad = 0, cyc = 0;
  int busy_cycles = 0, busy_cnt = 0, hold = 0, done_cnt = 0;
  bit chk_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic res_t mk_res(input logic w0, w1, mis, input logic [31:0] d0, d1,
                                  input logic [4:0] v, input int lat);
    res_t r;
    r.w0 = w0; r.w1 = w1; r.mis = mis; r.d0 = d0; r.d1 = d1; r.vd = v;
    r.acc_cyc = 0; r.lat = lat;
    return r;
  endfunction

  task automatic push_acc(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input int hold_c);
    acc_t a;
    a.wr = wr; a.addr = addr; a.be = be; a.wdata = wdata; a.hold = hold_c;
    acc_q.push_back(a);
  endtask

  always @(posedge CLK) cyc++;

  // Memory model: busy for busy_cycles cycles at the start of every strobe, read data from rd_vals.
  always @(posedge CLK) begin
    #1;
    if (!nRST) begin
      dmem_busy = 1'b0;
      busy_cnt  = 0;
    end else if (dmem_ren || dmem_wen) begin
      if (busy_cnt < busy_cycles) begin
        dmem_busy = 1'b1;
        busy_cnt++;
      end else begin
        dmem_busy = 1'b0;
        busy_cnt  = 0;
      end
      dmem_rdata = (rd_vals.size() > 0) ? rd_vals[0] : 32'h0;
    end else begin
      dmem_busy = 1'b0;
      busy_cnt  = 0;
    end
  end

  always @(negedge CLK) begin
    if (!nRST) begin
      hold = 0;
      chk_ready = 0;
    end else begin
      if (dmem_ren && dmem_wen) check("strobe_excl", {30'h0, dmem_ren, dmem_wen}, 32'h1);
      if (chk_ready) begin
        check("ready_after_done", {31'h0, mem_ready}, 32'h1);
        chk_ready = 0;
      end
      if (dmem_ren || dmem_wen) begin
        hold++;
        if (!dmem_busy) begin
          if (acc_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_access: addr=%h ren=%b wen=%b expected no access", dmem_addr, dmem_ren, dmem_wen);
          end else begin
            ea = acc_q.pop_front();
            check("acc_is_write", {31'h0, dmem_wen}, {31'h0, ea.wr});
            check("acc_addr", dmem_addr, ea.addr);
            check("acc_byte_en", {28'h0, dmem_byte_en}, {28'h0, ea.be});
            if (ea.wr) check("acc_wdata", dmem_wdata, ea.wdata);
            check("acc_hold_cycles", 32'(hold), 32'(ea.hold));
          end
          hold = 0;
          if (dmem_ren && rd_vals.size() > 0) void'(rd_vals.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        if (res_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: done=1 expected 0");
        end else begin
          er = res_q.pop_front();
          check("wb_wen0", {31'h0, wb_wen0}, {31'h0, er.w0});
          check("wb_wen1", {31'h0, wb_wen1}, {31'h0, er.w1});
          check("misaligned", {31'h0, misaligned}, {31'h0, er.mis});
          check("wb_vd", {27'h0, wb_vd}, {27'h0, er.vd});
          if (er.w0) check("wb_data0", wb_data0, er.d0);
          if (er.w1) check("wb_data1", wb_data1, er.d1);
          check("done_latency", 32'(cyc - er.acc_cyc), 32'(er.lat));
        end
        chk_ready = 1;
      end
    end
  end

  task automatic issue(input logic ld, st, w0, w1, input logic [31:0] a0, a1, d0, d1,
                       input logic [1:0] e, input logic [4:0] v, input bit expect_done, input res_t r);
    int n = 0;
    while (!mem_ready && n < 300) begin
      @(posedge CLK); #1; n++;
    end
    if (!mem_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: mem_ready=%b expected 1", mem_ready);
    end
    load = ld; store = st; wen0 = w0; wen1 = w1;
    aluresult0 = a0; aluresult1 = a1; storedata0 = d0; storedata1 = d1; eew = e; vd = v;
    @(posedge CLK); #1;
    load = 0; store = 0; wen0 = 0; wen1 = 0;
    if (expect_done) begin
      r.acc_cyc = cyc;
      res_q.push_back(r);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((res_q.size() != 0 || !mem_ready) && n < 300) begin
      @(posedge CLK); #1; n++;
    end
    if (res_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending=%0d expected 0", res_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    check("rst_mem_ready", {31'h0, mem_ready}, 32'h1);
    check("rst_strobes", {30'h0, dmem_ren, dmem_wen}, 32'h0);
    check("rst_done", {29'h0, done, wb_wen0, wb_wen1}, 32'h0);
    check("rst_misaligned", {31'h0, misaligned}, 32'h0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wb_data0", wb_data0, 32'h0);

    // 32b load, both lanes
    push_acc(0, 32'h100, 4'b1111, 32'h0, 1);
    push_acc(0, 32'h104, 4'b1111, 32'h0, 1);
    rd_vals.push_back(32'hAAAA5555); rd_vals.push_back(32'h12345678);
    issue(1, 0, 1, 1, 32'h100, 32'h104, 0, 0, 2'b10, 5'd3, 1,
          mk_res(1, 1, 0, 32'hAAAA5555, 32'h12345678, 5'd3, 2));
    drain();

    // 8b store into top byte
    push_acc(1, 32'h200, 4'b1000, 32'hEF000000, 1);
    issue(0, 1, 1, 0, 32'h203, 32'h0, 32'h000000EF, 32'h0, 2'b00, 5'd4, 1,
          mk_res(0, 0, 0, 0, 0, 5'd4, 1));
    drain();

    // 16b load lane1 only, memory busy 3 cycles
    busy_cycles = 3;
    push_acc(0, 32'h300, 4'b1100, 32'h0, 4);
    rd_vals.push_back(32'hBEEF0000);
    issue(1, 0, 0, 1, 32'h0, 32'h302, 0, 0, 2'b01, 5'd7, 1,
          mk_res(0, 1, 0, 0, 32'h0000BEEF, 5'd7, 4));
    drain();
    busy_cycles = 0;

    // misaligned lane0 skipped, lane1 read
    push_acc(0, 32'h108, 4'b1111, 32'h0, 1);
    rd_vals.push_back(32'hCAFEF00D);
    issue(1, 0, 1, 1, 32'h101, 32'h108, 0, 0, 2'b10, 5'd9, 1,
          mk_res(0, 1, 1, 0, 32'hCAFEF00D, 5'd9, 2));
    drain();

    // load and store together: load wins
    push_acc(0, 32'h40, 4'b1111, 32'h0, 1);
    rd_vals.push_back(32'h01020304);
    issue(1, 1, 1, 0, 32'h40, 32'h0, 32'h55, 0, 2'b10, 5'd10, 1,
          mk_res(1, 0, 0, 32'h01020304, 0, 5'd10, 1));
    drain();

    // 16b store, lane0 misaligned, lane1 upper half
    push_acc(1, 32'h500, 4'b1100, 32'hABCD0000, 1);
    issue(0, 1, 1, 1, 32'h501, 32'h502, 32'hFFFF, 32'h1234ABCD, 2'b01, 5'd11, 1,
          mk_res(0, 0, 1, 0, 0, 5'd11, 2));
    drain();

    // 8b loads from byte 2 and byte 1
    push_acc(0, 32'h60, 4'b0100, 32'h0, 1);
    push_acc(0, 32'h70, 4'b0010, 32'h0, 1);
    rd_vals.push_back(32'h11223344); rd_vals.push_back(32'h55667788);
    issue(1, 0, 1, 1, 32'h62, 32'h71, 0, 0, 2'b00, 5'd12, 1,
          mk_res(1, 1, 0, 32'h22, 32'h77, 5'd12, 2));
    drain();

    // 32b store
    push_acc(1, 32'h80, 4'b1111, 32'hDEADBEEF, 1);
    issue(0, 1, 1, 0, 32'h80, 32'h0, 32'hDEADBEEF, 0, 2'b10, 5'd13, 1,
          mk_res(0, 0, 0, 0, 0, 5'd13, 1));
    drain();

    // reserved element width: no access, misaligned reported
    issue(0, 1, 1, 0, 32'h0, 32'h0, 32'h1, 0, 2'b11, 5'd14, 1,
          mk_res(0, 0, 1, 0, 0, 5'd14, 1));
    drain();

    // request with no active lane is ignored
    load = 1; wen0 = 0; wen1 = 0; aluresult0 = 32'h900;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check("nolane_ready", {31'h0, mem_ready}, 32'h1);
      check("nolane_strobes", {30'h0, dmem_ren, dmem_wen}, 32'h0);
    end
    load = 0;

    // reset during a busy lane1 read
    begin
      int n = 0;
      int saved_done;
      busy_cycles = 10;
      push_acc(0, 32'hA00, 4'b1111, 32'h0, 11);
      rd_vals.push_back(32'h1); rd_vals.push_back(32'h2);
      issue(1, 0, 1, 1, 32'hA00, 32'hA04, 0, 0, 2'b10, 5'd15, 0, mk_res(0, 0, 0, 0, 0, 5'd0, 0));
      while (!(dmem_ren && dmem_addr == 32'hA04) && n < 100) begin
        @(posedge CLK); #1; n++;
      end
      check("lane1_reached", {31'h0, dmem_ren}, 32'h1);
      @(posedge CLK); #3;
      saved_done = done_cnt;
      nRST = 1'b0;
      #1;
      check("rst_drop_strobes", {30'h0, dmem_ren, dmem_wen}, 32'h0);
      check("rst_drop_ready", {31'h0, mem_ready}, 32'h1);
      rd_vals.delete();
      busy_cycles = 0;
      @(posedge CLK); #1;
      nRST = 1'b1;
      repeat (5) @(posedge CLK);
      #1;
      check("post_rst_ready", {31'h0, mem_ready}, 32'h1);
      check("post_rst_no_done", 32'(done_cnt), 32'(saved_done));
    end

    check("acc_queue_empty", 32'(acc_q.size()), 32'h0);
    check("res_queue_empty", 32'(res_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
